regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (waddr/wdata/we) between NUM_REQ
//  writeback requesters, e.g. 0=ALU, 1=load unit. Round-robin grant, one write per cycle.
//  Registered output stage drives the RegisterFile write inputs directly; x0 writes are dropped.
//  Forwards the in-flight write to two read addresses so decode sees it before it lands.
// PARAMETERS
//  NUM_REQ     2    number of writeback requesters (2..8)
//  ADDR_W      5    register address width
//  DATA_W      32   register data width
// PORTS
//  clk          in   1                 clock; all state updates on rising edge
//  reset        in   1                 synchronous, active-high reset
//  wb_hold      in   1                 1 = grant nothing this cycle (debug/freeze)
//  req_valid    in   NUM_REQ           requester i has a write pending
//  req_ready    out  NUM_REQ           requester i's write accepted this cycle
//  req_addr     in   NUM_REQ*ADDR_W    dest reg; slice i = [i*ADDR_W +: ADDR_W]
//  req_data     in   NUM_REQ*DATA_W    write data; slice i = [i*DATA_W +: DATA_W]
//  rf_waddr     out  ADDR_W            to rf_in.waddr (registered)
//  rf_wdata     out  DATA_W            to rf_in.wdata (registered)
//  rf_we        out  1                 to rf_in.we (registered)
//  fwd_rs1_addr in   ADDR_W            decode rs1 address
//  fwd_rs2_addr in   ADDR_W            decode rs2 address
//  fwd_rs1_hit  out  1                 rf_we & rf_waddr==fwd_rs1_addr (comb)
//  fwd_rs2_hit  out  1                 same for rs2 (comb)
//  fwd_rs1_data out  DATA_W            rf_wdata when fwd_rs1_hit, else 0
//  fwd_rs2_data out  DATA_W            rf_wdata when fwd_rs2_hit, else 0
// BEHAVIOUR
//  Reset: rf_we=0, rf_waddr=0, rf_wdata=0; req_ready=0 while reset=1; last_grant=NUM_REQ-1
//   (requester 0 highest priority in the first cycle after reset).
//  Handshake: transfer on req_valid[i] & req_ready[i]. req_ready is combinational from
//   req_valid, wb_hold, last_grant; requesters never make valid depend on ready.
//   Requester holds addr/data stable while valid & !ready.
//  Grant: if wb_hold=0 and any valid: exactly one-hot req_ready to the first valid requester
//   scanning last_grant+1, +2, ... modulo NUM_REQ. Otherwise req_ready=0.
//  last_grant updates to the granted index on a transfer; unchanged in idle/hold cycles.
//  Fairness: with all requesters continuously valid, each is granted exactly once per
//   NUM_REQ consecutive cycles.
//  Latency: transfer in cycle t -> rf_we=1 with that addr/data in cycle t+1 (1 cycle).
//   No transfer in t -> rf_we=0 in t+1; rf_waddr/rf_wdata hold previous values.
//  x0: transfer with addr==0 is consumed (ready=1, last_grant advances) but rf_we=0 in t+1.
//  Forwarding is from the output register only (the write landing this cycle); addr 0 never
//   hits since rf_we is never 1 with rf_waddr=0.
//  wb_hold=1: no grants; a write already in the output register still issues next cycle.
//  Reset mid-operation: output register write lost (rf_we=0 the cycle after reset);
//   requesters re-present after reset deasserts.
//  Stateful elements: last_grant, rf_waddr, rf_wdata, rf_we only; no queueing.
// TESTING
//  1 Single req: valid0, addr=5, data=0xDEADBEEF -> ready0 same cycle; next cycle rf_we=1,
//    rf_waddr=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
//  2 Contention: both valid 4 cycles after reset (r0 addr=1, r1 addr=2) -> grants 0,1,0,1;
//    rf_waddr sequence 1,2,1,2 one cycle delayed.
//  3 x0: r1 valid addr=0 data=0x1234 -> ready1=1, rf_we stays 0; next grant goes to r0.
//  4 Hold: both valid, wb_hold=1 for 3 cycles -> req_ready=0, rf_we=0 after the in-flight write;
//    on release, grant order resumes from last_grant+1.
//  5 Forward: write addr=7 data=0xA5A5A5A5 landing, fwd_rs1_addr=7, fwd_rs2_addr=8 ->
//    fwd_rs1_hit=1 data=0xA5A5A5A5, fwd_rs2_hit=0 data=0.
//  6 Reset: assert reset 1 cycle right after a transfer -> rf_we=0 next cycle, ready=0 during
//    reset, first post-reset grant goes to r0 when both valid.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback
// requesters. The output stage is registered, writes to x0 are dropped, and the write
// held in the output register is forwarded to two decode read addresses.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      rf_we,
  input  logic [ADDR_W-1:0]         fwd_rs1_addr,
  input  logic [ADDR_W-1:0]         fwd_rs2_addr,
  output logic                      fwd_rs1_hit,
  output logic                      fwd_rs2_hit,
  output logic [DATA_W-1:0]         fwd_rs1_data,
  output logic [DATA_W-1:0]         fwd_rs2_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              rf_we_q, rf_we_d;

  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  int                scan_idx;

  // Scan starts just past the last winner, so the previous winner is checked last.
  always_comb begin
    req_ready   = '0;
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    sel_addr    = '0;
    sel_data    = '0;
    scan_idx    = 0;
    if (!reset && !wb_hold) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        scan_idx = (int'(last_grant_q) + i) % NUM_REQ;
        if (!grant_found && req_valid[scan_idx]) begin
          grant_found         = 1'b1;
          grant_idx           = IDX_W'(scan_idx);
          req_ready[scan_idx] = 1'b1;
          sel_addr            = req_addr[scan_idx*ADDR_W +: ADDR_W];
          sel_data            = req_data[scan_idx*DATA_W +: DATA_W];
        end
      end
    end
  end

  // An x0 write is still consumed and advances the pointer; it just never reaches the file.
  always_comb begin
    last_grant_d = last_grant_q;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    rf_we_d      = 1'b0;
    if (grant_found) begin
      last_grant_d = grant_idx;
      if (sel_addr != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = sel_addr;
        rf_wdata_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      rf_we_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_we_q      <= rf_we_d;
    end
  end

  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign rf_we    = rf_we_q;

  assign fwd_rs1_hit  = rf_we_q && (rf_waddr_q == fwd_rs1_addr);
  assign fwd_rs2_hit  = rf_we_q && (rf_waddr_q == fwd_rs2_addr);
  assign fwd_rs1_data = fwd_rs1_hit ? rf_wdata_q : '0;
  assign fwd_rs2_data = fwd_rs2_hit ? rf_wdata_q : '0;

endmodule
